// File: rtl/vect_post_proc.sv
// Purpose : CORDIC vectoring post-processing: removes CORDIC gain, restores full-circle angle.
// Latency : 3 cycles (S1 clamp/multiply, S2 round/angle fixup, S3 output register).
// Backpr. : global stall; all stages hold while out_valid && !out_ready, in_ready = en.
//
// Ports:
//   clk, rst                 sole clock, asynchronous active-low reset
//   in_valid / in_ready      input handshake; in_ready depends only on out_valid/out_ready
//   r_raw, angle_raw         signed raw magnitude (gain ~1.64676) and angle in 0.01 deg, [-9000, 9000]
//   in_xneg, in_yneg         quadrant tags from the upstream pre-rotation
//   out_valid / out_ready    output handshake
//   r_out, angle_out         gain-corrected magnitude (>= 0), full-circle angle in (-18000, 18000]
module vect_post_proc #(
  parameter int W    = 16,
  parameter int KINV = 19898
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] r_raw,
  input  logic signed [W-1:0] angle_raw,
  input  logic                in_xneg,
  input  logic                in_yneg,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] r_out,
  output logic signed [W-1:0] angle_out
);

  localparam logic [2*W-1:0]  KINV_X    = (2*W)'(KINV);
  localparam logic [2*W-1:0]  RND_HALF  = (2*W)'(16384);
  localparam logic signed [W:0] HALF_TURN = (W+1)'(18000);

  // Stage 1: clamped magnitude, raw angle, tags
  logic                v1_q;
  logic signed [W-1:0] r1_q, r1_d;
  logic signed [W-1:0] a1_q;
  logic                xn1_q, yn1_q;

  // Stage 2: rounded magnitude, fixed-up angle
  logic                v2_q;
  logic signed [W-1:0] r2_q, r2_d;
  logic signed [W-1:0] a2_q, a2_d;

  // Stage 3: output register
  logic                v3_q;
  logic signed [W-1:0] r3_q;
  logic signed [W-1:0] a3_q;

  logic                en;
  logic [2*W-1:0]      p;
  logic signed [W:0]   a_ext;
  logic signed [W:0]   a_fix;

  // Stall only when the output holds a sample nobody takes; empty slots always fill.
  assign en       = !(v3_q && !out_ready);
  assign in_ready = en;

  assign out_valid = v3_q;
  assign r_out     = r3_q;
  assign angle_out = a3_q;

  always_comb begin
    r1_d  = r_raw[W-1] ? '0 : r_raw;

    // r1_q is non-negative after the clamp, so an unsigned product is exact.
    p     = (2*W)'(r1_q) * KINV_X;
    r2_d  = W'((p + RND_HALF) >> 15);

    a_ext = (W+1)'(a1_q);
    a_fix = a_ext;
    if (xn1_q && !yn1_q) begin
      // Includes x<0, y=0: angle 0 becomes +18000, never -18000.
      a_fix = a_ext + HALF_TURN;
    end else if (xn1_q && yn1_q) begin
      a_fix = a_ext - HALF_TURN;
    end
    // A zero vector has no meaningful direction; report angle 0.
    a2_d  = (r1_q == '0) ? '0 : W'(a_fix);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q  <= 1'b0;
      r1_q  <= '0;
      a1_q  <= '0;
      xn1_q <= 1'b0;
      yn1_q <= 1'b0;
      v2_q  <= 1'b0;
      r2_q  <= '0;
      a2_q  <= '0;
      v3_q  <= 1'b0;
      r3_q  <= '0;
      a3_q  <= '0;
    end else if (en) begin
      v1_q  <= in_valid;
      r1_q  <= r1_d;
      a1_q  <= angle_raw;
      xn1_q <= in_xneg;
      yn1_q <= in_yneg;
      v2_q  <= v1_q;
      r2_q  <= r2_d;
      a2_q  <= a2_d;
      v3_q  <= v2_q;
      r3_q  <= r2_q;
      a3_q  <= a2_q;
    end
  end

endmodule

// File: tb/tb_vect_post_proc.sv
module tb_vect_post_proc;
  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic signed [W-1:0] r_raw = '0;
  logic signed [W-1:0] angle_raw = '0;
  logic                in_xneg = 1'b0;
  logic                in_yneg = 1'b0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic signed [W-1:0] r_out;
  logic signed [W-1:0] angle_out;

  typedef struct {
    int r;
    int a;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_err = 0;
  bit   lat_chk = 1'b0;

  vect_post_proc #(.W(W), .KINV(19898)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .r_raw     (r_raw),
    .angle_raw (angle_raw),
    .in_xneg   (in_xneg),
    .in_yneg   (in_yneg),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .r_out     (r_out),
    .angle_out (angle_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int r, input int a, input bit xn, input bit yn, input int c);
    exp_t e;
    int   rc;
    rc = (r < 0) ? 0 : r;
    e.r = (rc * 19898 + 16384) >>> 15;
    if (rc == 0)        e.a = 0;
    else if (xn && !yn) e.a = a + 18000;
    else if (xn && yn)  e.a = a - 18000;
    else                e.a = a;
    e.cyc = c;
    return e;
  endfunction

  // Present one sample (caller is just after a rising edge); returns just after the accepting edge.
  task automatic send(input int r, input int a, input bit xn, input bit yn);
    int n;
    in_valid  = 1'b1;
    r_raw     = 16'(r);
    angle_raw = 16'(a);
    in_xneg   = xn;
    in_yneg   = yn;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    else sb.push_back(model(r, a, xn, yn, cyc));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", sb.size(), 0);
      sb.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Output scoreboard: every completed output handshake is checked against the queue head.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("spurious_out", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("r_out", int'(r_out), e.r);
        chk("angle_out", int'(angle_out), e.a);
        if (lat_chk) chk("latency", cyc - e.cyc, 3);
      end
    end
  end

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_r_out", int'(r_out), 0);
    chk("rst_angle_out", int'(angle_out), 0);
    #20 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("in_ready_after_rst", int'(in_ready), 1);
    @(posedge clk); #1;

    // Directed vectors: 3-4-5, axis, x<0 y=0, third quadrant, zero vector, negative r
    lat_chk = 1'b1;
    send(823, 5313, 1'b0, 1'b0);
    send(659, 9000, 1'b0, 1'b0);
    send(659, 0, 1'b1, 1'b0);
    send(823, 5313, 1'b1, 1'b1);
    send(0, 1234, 1'b1, 1'b1);
    send(-5, 500, 1'b0, 1'b0);
    send(-5, -700, 1'b1, 1'b1);
    send(823, -5313, 1'b0, 1'b1);
    send(823, -5313, 1'b1, 1'b0);
    drain();

    // Backpressure: 6 back-to-back samples, 4-cycle stall after the first output
    lat_chk = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(1000 + i * 3001, i * 1500 - 4000, i[0], i[1]);
      end
      begin : stall
        int n;
        int hr;
        int ha;
        n = 0;
        while (!out_valid && n < 40) begin
          @(negedge clk);
          n++;
        end
        if (!out_valid) chk("first_out_timeout", 0, 1);
        @(posedge clk); #1;
        out_ready = 1'b0;
        hr = int'(r_out);
        ha = int'(angle_out);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          chk("stall_in_ready", int'(in_ready), 0);
          chk("stall_out_valid", int'(out_valid), 1);
          chk("stall_r_hold", int'(r_out), hr);
          chk("stall_a_hold", int'(angle_out), ha);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset mid-stream with data in flight
    for (int i = 0; i < 4; i++) send(2000 + i * 100, 100 * i, 1'b0, 1'b0);
    #3;
    chk("pre_rst_out_valid", int'(out_valid), 1);
    rst = 1'b0;
    #1;
    chk("mid_rst_out_valid", int'(out_valid), 0);
    chk("mid_rst_r_out", int'(r_out), 0);
    chk("mid_rst_angle_out", int'(angle_out), 0);
    sb.delete();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    chk("in_ready_after_mid_rst", int'(in_ready), 1);
    repeat (5) @(posedge clk);
    #1;
    lat_chk = 1'b1;
    send(823, -5313, 1'b0, 1'b1);
    drain();

    // Full rate random samples
    for (int i = 0; i < 20; i++)
      send(int'($urandom_range(32967)) - 200, int'($urandom_range(18000)) - 9000,
           1'(($urandom_range(1))), 1'(($urandom_range(1))));
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
